rcpu_memory: RTL and testbench

Memory-side responder for the RCPU memory port. It answers every CPU address with combinational read data, commits writes on the clock edge, and decodes a small I/O window. The window holds an output-word FIFO with a valid/ready stream, a one-word input holding register and a free-running tick counter. It sits directly opposite the CPU's memAddr/memRead/memWrite/memWE pins and is the only device on that bus.

---
 rtl/rcpu_memory_pkg.sv | 52 +++++
 rtl/rcpu_fifo.sv | 63 ++++++
 rtl/rcpu_memory.sv | 141 ++++++++++++++
 tb/tb_rcpu_memory.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcpu_memory_pkg.sv
// Shared constants for the RCPU memory responder: I/O window offsets,
// STATUS bit positions and the window decode helpers.
package rcpu_memory_pkg;

  localparam logic [7:0] IO_OUT    = 8'h00;
  localparam logic [7:0] IO_STATUS = 8'h01;
  localparam logic [7:0] IO_IN     = 8'h02;
  localparam logic [7:0] IO_TICK   = 8'h03;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT,
    SEL_STATUS,
    SEL_IN,
    SEL_TICK,
    SEL_NONE
  } sel_e;

  function automatic sel_e io_select(input logic [7:0] off);
    sel_e s;
    case (off)
      IO_OUT:    s = SEL_OUT;
      IO_STATUS: s = SEL_STATUS;
      IO_IN:     s = SEL_IN;
      IO_TICK:   s = SEL_TICK;
      default:   s = SEL_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] pack_status(input logic [3:0] cnt,
                                             input logic       ovf,
                                             input logic       rx_valid,
                                             input logic       empty,
                                             input logic       full);
    logic [7:0] s;
    s                             = '0;
    s[ST_COUNT_LSB +: 4]          = cnt;
    s[ST_OVF]                     = ovf;
    s[ST_RX_VALID]                = rx_valid;
    s[ST_EMPTY]                   = empty;
    s[ST_FULL]                    = full;
    return s;
  endfunction

endpackage

// File: rtl/rcpu_fifo.sv
// Output-word FIFO for the RCPU memory responder. A push while full is
// accepted only when a pop happens on the same edge; otherwise it is dropped.
module rcpu_fifo #(
  parameter int M          = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [M-1:0]                       din,
  output logic [M-1:0]                       dout,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

  logic [M-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; emptiness is defined by the count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcpu_memory.sv
// Memory-side responder for the RCPU bus: RAM below IO_BASE, I/O window above.
// Define RCPU_MEM_TICK_EN to build the free-running TICK counter at offset 3.
module rcpu_memory
  import rcpu_memory_pkg::*;
#(
  parameter int             M          = 16,
  parameter int             RAM_AW     = 12,
  parameter int             FIFO_DEPTH = 8,
  parameter logic [M-1:0]   IO_BASE    = 16'hFF00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] memAddr,
  output logic [M-1:0] memRead,
  input  logic [M-1:0] memWrite,
  input  logic         memWE,
  output logic [M-1:0] outData,
  output logic         outValid,
  input  logic         outReady,
  input  logic [M-1:0] inData,
  input  logic         inValid,
  output logic         inReady
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          is_io;
  sel_e          sel;
  logic          wr_ram;
  logic          wr_status;
  logic          wr_in;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [M-1:0]  fifo_dout;
  logic [3:0]    count4;

  logic          ovf;
  logic          rx_valid;
  logic [M-1:0]  rx_word;
  logic [M-1:0]  tick_rd;
  logic [7:0]    status8;

  logic [M-1:0]  ram [2**RAM_AW];

  assign is_io     = (memAddr >= IO_BASE);
  assign sel       = is_io ? io_select(memAddr[7:0]) : SEL_RAM;
  assign wr_ram    = memWE && rst && (sel == SEL_RAM);
  assign wr_status = memWE && (sel == SEL_STATUS);
  assign wr_in     = memWE && (sel == SEL_IN);

  // Both streams use valid/ready: a word transfers on an edge where both
  // valid and ready are high; valid never waits on ready.
  assign fifo_push = memWE && (sel == SEL_OUT);
  assign fifo_pop  = outValid && outReady;
  assign outValid  = !fifo_empty;
  assign outData   = fifo_dout;
  assign inReady   = rst && !rx_valid;

  rcpu_fifo #(
    .M          (M),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (memWrite),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[memAddr[RAM_AW-1:0]] <= memWrite;
    end
  end

  // A dropped push sets OVF even if the same edge carries a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      ovf <= 1'b1;
    end else if (wr_status && memWrite[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      rx_word  <= '0;
    end else if (wr_in) begin
      rx_valid <= 1'b0;
    end else if (inValid && inReady) begin
      rx_valid <= 1'b1;
      rx_word  <= inData;
    end
  end

`ifdef RCPU_MEM_TICK_EN
  logic [M-1:0] tick;
  logic         wr_tick;

  assign wr_tick = memWE && (sel == SEL_TICK);
  assign tick_rd = tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= '0;
    end else if (wr_tick) begin
      tick <= memWrite;
    end else begin
      tick <= tick + M'(1);
    end
  end
`else
  assign tick_rd = '0;
`endif

  assign count4  = 4'(fifo_count);
  assign status8 = pack_status(count4, ovf, rx_valid, fifo_empty, fifo_full);

  always_comb begin
    memRead = '0;
    case (sel)
      SEL_RAM:    memRead = ram[memAddr[RAM_AW-1:0]];
      SEL_STATUS: memRead[7:0] = status8;
      SEL_IN:     memRead = rx_valid ? rx_word : '0;
      SEL_TICK:   memRead = tick_rd;
      default:    memRead = '0;
    endcase
  end

endmodule

// File: tb/tb_rcpu_memory.sv
// Bench for rcpu_memory: a queue/array model checked every cycle plus
// directed vectors with literal expectations.
module tb_rcpu_memory;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_read;
  logic [15:0] mem_write = '0;
  logic        mem_we = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  rcpu_memory #(
    .M(16), .RAM_AW(12), .FIFO_DEPTH(DEPTH), .IO_BASE(16'hFF00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memAddr  (mem_addr),
    .memRead  (mem_read),
    .memWrite (mem_write),
    .memWE    (mem_we),
    .outData  (out_data),
    .outValid (out_valid),
    .outReady (out_ready),
    .inData   (in_data),
    .inValid  (in_valid),
    .inReady  (in_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state
  logic [15:0] exp_q[$];
  logic [15:0] ram_m[int];
  logic        m_ovf  = 1'b0;
  logic        m_rxv  = 1'b0;
  logic [15:0] m_held = '0;
  logic [15:0] m_tick = '0;
  logic        m_is_io;
  logic [7:0]  m_off;
  logic        m_pop;

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s = '0;
    s[7:4] = 4'(exp_q.size());
    s[3]   = m_ovf;
    s[2]   = m_rxv;
    s[1]   = (exp_q.size() == 0);
    s[0]   = (exp_q.size() == DEPTH);
    return s;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, output bit known);
    known = 1'b1;
    if (a < 16'hFF00) begin
      if (ram_m.exists(int'(a[11:0]))) return ram_m[int'(a[11:0])];
      known = 1'b0;
      return '0;
    end
    case (a[7:0])
      8'h01:   return model_status();
      8'h02:   return m_rxv ? m_held : 16'h0000;
`ifdef RCPU_MEM_TICK_EN
      8'h03:   return m_tick;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_rxv  = 1'b0;
      m_held = '0;
      m_tick = '0;
    end else begin
      m_is_io = (mem_addr >= 16'hFF00);
      m_off   = mem_addr[7:0];
      m_pop   = (exp_q.size() != 0) && out_ready;
      if (mem_we && !m_is_io) ram_m[int'(mem_addr[11:0])] = mem_write;
      if (m_pop) void'(exp_q.pop_front());
      if (mem_we && m_is_io && m_off == 8'h00) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(mem_write);
        else m_ovf = 1'b1;
      end else if (mem_we && m_is_io && m_off == 8'h01 && mem_write[3]) begin
        m_ovf = 1'b0;
      end
      if (mem_we && m_is_io && m_off == 8'h02) m_rxv = 1'b0;
      else if (in_valid && !m_rxv) begin
        m_rxv  = 1'b1;
        m_held = in_data;
      end
      if (mem_we && m_is_io && m_off == 8'h03) m_tick = mem_write;
      else m_tick = m_tick + 16'd1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every negedge the outputs must match the model
  always @(negedge clk) begin
    logic [15:0] er;
    bit          known;
    chk("out_valid", {15'd0, out_valid}, {15'd0, exp_q.size() != 0});
    chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
    chk("in_ready", {15'd0, in_ready}, {15'd0, rst && !m_rxv});
    er = model_read(mem_addr, known);
    if (known) chk("mem_read", mem_read, er);
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr  = a;
    mem_write = d;
    mem_we    = 1'b1;
    cyc();
    mem_we    = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    mem_addr = a;
    mem_we   = 1'b0;
    @(negedge clk);
    chk(name, mem_read, exp);
    cyc();
  endtask

  logic [15:0] pp_exp[8];

  initial begin
    // reset state
    repeat (2) cyc();
    mem_addr = 16'hFF01;
    @(negedge clk);
    chk("rst_status", mem_read, 16'h0002);
    chk("rst_in_ready", {15'd0, in_ready}, 16'h0000);
    cyc();
    rst = 1'b1;
    mem_addr = 16'hFF03;
    @(negedge clk);
    chk("tick_first", mem_read, 16'h0000);
    cyc();
    @(negedge clk);
`ifdef RCPU_MEM_TICK_EN
    chk("tick_after_edge", mem_read, 16'h0001);
`else
    chk("tick_absent", mem_read, 16'h0000);
`endif
    cyc();

    // RAM, aliasing and the last RAM address below the window
    wr(16'h0010, 16'h1234);
    rd_chk("ram_rd", 16'h0010, 16'h1234);
    rd_chk("ram_alias", 16'h1010, 16'h1234);
    wr(16'h0FFF, 16'hFFFF);
    wr(16'hFEFF, 16'h7777);
    rd_chk("ram_top", 16'h0EFF, 16'h7777);
    rd_chk("ram_fff", 16'h0FFF, 16'hFFFF);

    // FIFO fill with overflow
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(16'hFF00, 16'(i));
    mem_addr = 16'hFF01;
    @(negedge clk);
    chk("fill_status", mem_read, 16'h0089);
    chk("fill_valid", {15'd0, out_valid}, 16'h0001);
    chk("fill_head", out_data, 16'h0001);
    cyc();
    rd_chk("out_reads_zero", 16'hFF00, 16'h0000);

    // drain
    out_ready = 1'b1;
    mem_addr  = 16'h0010;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("drain_word", out_data, 16'(i));
      cyc();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", {15'd0, out_valid}, 16'h0000);
    cyc();
    rd_chk("drain_status", 16'hFF01, 16'h000A);
    wr(16'hFF01, 16'h0008);
    rd_chk("ovf_clear", 16'hFF01, 16'h0002);

    // push and pop on the same edge while full
    for (int i = 1; i <= 8; i++) wr(16'hFF00, 16'h0100 + 16'(i));
    rd_chk("full_status", 16'hFF01, 16'h0081);
    out_ready = 1'b1;
    wr(16'hFF00, 16'hAAAA);
    out_ready = 1'b0;
    rd_chk("pp_status", 16'hFF01, 16'h0081);
    for (int i = 0; i < 7; i++) pp_exp[i] = 16'h0102 + 16'(i);
    pp_exp[7] = 16'hAAAA;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pp_word", out_data, pp_exp[i]);
      cyc();
    end
    out_ready = 1'b0;

    // input holding register
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    @(negedge clk);
    chk("in_ready_idle", {15'd0, in_ready}, 16'h0001);
    cyc();
    in_valid = 1'b0;
    mem_addr = 16'hFF02;
    @(negedge clk);
    chk("in_ready_held", {15'd0, in_ready}, 16'h0000);
    chk("in_word", mem_read, 16'h5A5A);
    cyc();
    rd_chk("in_status", 16'hFF01, 16'h0006);
    wr(16'hFF02, 16'h0000);
    mem_addr = 16'hFF02;
    @(negedge clk);
    chk("in_cleared", mem_read, 16'h0000);
    chk("in_ready_again", {15'd0, in_ready}, 16'h0001);
    cyc();

    // clear and offer on the same edge: clear wins
    in_valid = 1'b1;
    in_data  = 16'h1111;
    cyc();
    in_data   = 16'h2222;
    mem_addr  = 16'hFF02;
    mem_write = 16'h0000;
    mem_we    = 1'b1;
    cyc();
    mem_we = 1'b0;
    @(negedge clk);
    chk("clr_wins_rd", mem_read, 16'h0000);
    chk("clr_wins_ready", {15'd0, in_ready}, 16'h0001);
    cyc();
    @(negedge clk);
    chk("relatch", mem_read, 16'h2222);
    cyc();
    in_valid = 1'b0;

    // unused offset
    wr(16'hFF10, 16'hBEEF);
    rd_chk("other_off", 16'hFF10, 16'h0000);

    // tick load and wrap
    wr(16'hFF03, 16'hFFFE);
    mem_addr = 16'hFF03;
`ifdef RCPU_MEM_TICK_EN
    @(negedge clk); chk("tick_fffe", mem_read, 16'hFFFE); cyc();
    @(negedge clk); chk("tick_ffff", mem_read, 16'hFFFF); cyc();
    @(negedge clk); chk("tick_wrap", mem_read, 16'h0000); cyc();
`else
    @(negedge clk); chk("tick_ignored", mem_read, 16'h0000); cyc();
`endif

    // asynchronous reset mid-transfer
    wr(16'hFF00, 16'hC001);
    wr(16'hFF00, 16'hC002);
    in_valid = 1'b1;
    in_data  = 16'h3333;
    cyc();
    in_valid = 1'b0;
    mem_addr = 16'hFF03;
    rst = 1'b0;
    #1;
    chk("arst_valid", {15'd0, out_valid}, 16'h0000);
    chk("arst_data", out_data, 16'h0000);
    chk("arst_in_ready", {15'd0, in_ready}, 16'h0000);
    chk("arst_tick", mem_read, 16'h0000);
    mem_addr = 16'hFF02;
    #1;
    chk("arst_in", mem_read, 16'h0000);
    mem_addr = 16'hFF01;
    #1;
    chk("arst_status", mem_read, 16'h0002);
    cyc();
    rst = 1'b1;
    rd_chk("ram_kept", 16'h0010, 16'h1234);
    rd_chk("post_rst_status", 16'hFF01, 16'h0002);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
